// File: rtl/spu_dual_issue_scheduler_if.sv
// spu_dual_issue_scheduler_if: decoder-to-scheduler slot pair and pipe-routing outputs
interface spu_dual_issue_scheduler_if #(
  parameter int NREG   = 128,
  parameter int LATW   = 3,
  parameter int STALLW = 32
);
  localparam int AW = $clog2(NREG);
  logic              in_valid0, in_valid1;
  logic              in_pipe0, in_pipe1;
  logic [AW-1:0]     in_ra0, in_rb0, in_rc0, in_rt0;
  logic [AW-1:0]     in_ra1, in_rb1, in_rc1, in_rt1;
  logic [2:0]        in_use0, in_use1;
  logic              in_wr0, in_wr1;
  logic [LATW-1:0]   in_lat0, in_lat1;
  logic              accept0, accept1;
  logic              ev_valid, od_valid;
  logic              ev_slot, od_slot;
  logic [STALLW-1:0] stall_cnt;
  modport master (
    output in_valid0, in_valid1, in_pipe0, in_pipe1,
           in_ra0, in_rb0, in_rc0, in_rt0, in_ra1, in_rb1, in_rc1, in_rt1,
           in_use0, in_use1, in_wr0, in_wr1, in_lat0, in_lat1,
    input  accept0, accept1, ev_valid, od_valid, ev_slot, od_slot, stall_cnt
  );
  modport slave (
    input  in_valid0, in_valid1, in_pipe0, in_pipe1,
           in_ra0, in_rb0, in_rc0, in_rt0, in_ra1, in_rb1, in_rc1, in_rt1,
           in_use0, in_use1, in_wr0, in_wr1, in_lat0, in_lat1,
    output accept0, accept1, ev_valid, od_valid, ev_slot, od_slot, stall_cnt
  );
endinterface

// File: rtl/spu_dual_issue_scheduler.sv
// spu_dual_issue_scheduler: in-order dual-issue with per-register pending-write scoreboard
module spu_dual_issue_scheduler #(
  parameter int NREG   = 128,
  parameter int LATW   = 3,
  parameter int STALLW = 32
) (
  input logic clk,
  input logic reset,
  spu_dual_issue_scheduler_if.slave bus
);
  localparam int AW = $clog2(NREG);
  logic [LATW-1:0]   cnt_q [NREG];
  logic [LATW-1:0]   cnt_d [NREG];
  logic [LATW-1:0]   eff0, eff1;
  logic              haz0, haz1, dep, acc0, acc1;
  logic              ev_valid_q, ev_valid_d, ev_slot_q, ev_slot_d;
  logic              od_valid_q, od_valid_d, od_slot_q, od_slot_d;
  logic [STALLW-1:0] stall_q, stall_d;
  // hazard detection and issue decision; nothing issues while reset is held
  always_comb begin
    haz0 = (bus.in_use0[0] && cnt_q[bus.in_ra0] != '0) || (bus.in_use0[1] && cnt_q[bus.in_rb0] != '0) ||
           (bus.in_use0[2] && cnt_q[bus.in_rc0] != '0) || (bus.in_wr0 && cnt_q[bus.in_rt0] != '0);
    haz1 = (bus.in_use1[0] && cnt_q[bus.in_ra1] != '0) || (bus.in_use1[1] && cnt_q[bus.in_rb1] != '0) ||
           (bus.in_use1[2] && cnt_q[bus.in_rc1] != '0) || (bus.in_wr1 && cnt_q[bus.in_rt1] != '0);
    dep  = bus.in_wr0 && ((bus.in_use1[0] && bus.in_rt0 == bus.in_ra1) || (bus.in_use1[1] && bus.in_rt0 == bus.in_rb1) ||
           (bus.in_use1[2] && bus.in_rt0 == bus.in_rc1) || (bus.in_wr1 && bus.in_rt0 == bus.in_rt1));
    acc0 = !reset && bus.in_valid0 && !haz0;
    acc1 = acc0 && bus.in_valid1 && !haz1 && (bus.in_pipe1 != bus.in_pipe0) && !dep;
  end
  assign bus.accept0 = acc0;
  assign bus.accept1 = acc1;
  // next state: counter holds remaining busy cycles, so a latency of L blocks readers for L-1 cycles
  always_comb begin
    eff0 = bus.in_lat0 - LATW'(bus.in_lat0 != '0);
    eff1 = bus.in_lat1 - LATW'(bus.in_lat1 != '0);
    for (int i = 0; i < NREG; i++)
      cnt_d[i] = (acc0 && bus.in_wr0 && bus.in_rt0 == AW'(i)) ? eff0 :
                 (acc1 && bus.in_wr1 && bus.in_rt1 == AW'(i)) ? eff1 :
                 cnt_q[i] - LATW'(cnt_q[i] != '0);
    ev_valid_d = (acc0 && !bus.in_pipe0) || (acc1 && !bus.in_pipe1);
    ev_slot_d  = (acc0 && !bus.in_pipe0) ? 1'b0 : (acc1 && !bus.in_pipe1) ? 1'b1 : ev_slot_q;
    od_valid_d = (acc0 && bus.in_pipe0) || (acc1 && bus.in_pipe1);
    od_slot_d  = (acc0 && bus.in_pipe0) ? 1'b0 : (acc1 && bus.in_pipe1) ? 1'b1 : od_slot_q;
    stall_d    = stall_q + STALLW'(bus.in_valid0 && !acc0 && stall_q != '1);
  end
  // state registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
      ev_valid_q <= 1'b0;
      ev_slot_q  <= 1'b0;
      od_valid_q <= 1'b0;
      od_slot_q  <= 1'b0;
      stall_q    <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
      ev_valid_q <= ev_valid_d;
      ev_slot_q  <= ev_slot_d;
      od_valid_q <= od_valid_d;
      od_slot_q  <= od_slot_d;
      stall_q    <= stall_d;
    end
  end
  assign bus.ev_valid  = ev_valid_q;
  assign bus.ev_slot   = ev_slot_q;
  assign bus.od_valid  = od_valid_q;
  assign bus.od_slot   = od_slot_q;
  assign bus.stall_cnt = stall_q;
endmodule
